// File: rtl/spi_flash_responder.sv
// SPI-NOR flash target model: decodes READ/PP/WREN/WRDI/CE/RDSR over a mode-0 link
// sampled in the clk domain and serves them from an internal byte array.
module spi_flash_responder #(
    parameter int unsigned ADDR_BITS   = 10,  // must be >= 8 (256-byte pages)
    parameter int unsigned PROG_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sck_i,
    input  logic cs_i,
    input  logic mosi_i,
    output logic miso_o,
    output logic wip_o,
    output logic wel_o,
    output logic cmd_error_o
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;
    localparam int unsigned CntW  = $clog2(PROG_CYCLES + 1);

    localparam logic [7:0] OpPp   = 8'h02;
    localparam logic [7:0] OpRead = 8'h03;
    localparam logic [7:0] OpWrdi = 8'h04;
    localparam logic [7:0] OpRdsr = 8'h05;
    localparam logic [7:0] OpWren = 8'h06;
    localparam logic [7:0] OpCe   = 8'hC7;
    localparam logic [7:0] OpNone = 8'h00;

    typedef enum logic [2:0] {
        StIdle, StOpcode, StAddr, StRead, StProg, StStatus, StSkip
    } state_e;

    logic [2:0]           sck_sync_q, cs_sync_q;
    logic [1:0]           mosi_sync_q;
    state_e               state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [ADDR_BITS-2:0] shift_q, shift_d;
    logic [7:0]           opcode_q, opcode_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           tx_q, tx_d;
    logic                 load_q, load_d;
    logic                 miso_q, miso_d;
    logic                 wel_q, wel_d;
    logic                 wip_q, wip_d;
    logic [CntW-1:0]      wip_cnt_q, wip_cnt_d;
    logic                 cmd_error_q, cmd_error_d;
    logic                 commit_q, commit_d;
    logic                 committed_q, committed_d;
    logic                 extra_q, extra_d;
    logic                 erase_q, erase_d;
    logic [ADDR_BITS-1:0] erase_addr_q, erase_addr_d;

    // Array holds inverted bytes so a zero-initialised memory reads back as erased 0xFF.
    logic [7:0]           mem_n [Depth];
    logic [7:0]           rd_data_q;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [7:0]           mem_wdata_n;

    logic                 sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
    logic [ADDR_BITS-1:0] shift_in, addr_pg;
    logic [7:0]           status;

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
    assign mosi_s   = mosi_sync_q[1];
    assign shift_in = {shift_q, mosi_s};
    assign status   = {6'b0, wel_q, wip_q};

    always_comb begin
        addr_pg      = addr_q;
        addr_pg[7:0] = addr_q[7:0] + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_n[mem_waddr] <= mem_wdata_n;
        end
        rd_data_q <= ~mem_n[addr_q];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q   <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            opcode_q     <= OpNone;
            addr_q       <= '0;
            tx_q         <= '0;
            load_q       <= 1'b0;
            miso_q       <= 1'b0;
            wel_q        <= 1'b0;
            wip_q        <= 1'b0;
            wip_cnt_q    <= '0;
            cmd_error_q  <= 1'b0;
            commit_q     <= 1'b0;
            committed_q  <= 1'b0;
            extra_q      <= 1'b0;
            erase_q      <= 1'b0;
            erase_addr_q <= '0;
        end else begin
            sck_sync_q   <= {sck_sync_q[1:0], sck_i};
            cs_sync_q    <= {cs_sync_q[1:0], cs_i};
            mosi_sync_q  <= {mosi_sync_q[0], mosi_i};
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            opcode_q     <= opcode_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            load_q       <= load_d;
            miso_q       <= miso_d;
            wel_q        <= wel_d;
            wip_q        <= wip_d;
            wip_cnt_q    <= wip_cnt_d;
            cmd_error_q  <= cmd_error_d;
            commit_q     <= commit_d;
            committed_q  <= committed_d;
            extra_q      <= extra_d;
            erase_q      <= erase_d;
            erase_addr_q <= erase_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        opcode_d     = opcode_q;
        addr_d       = addr_q;
        tx_d         = tx_q;
        load_d       = load_q;
        miso_d       = miso_q;
        wel_d        = wel_q;
        wip_d        = wip_q;
        wip_cnt_d    = wip_cnt_q;
        cmd_error_d  = 1'b0;
        commit_d     = 1'b0;
        committed_d  = committed_q;
        extra_d      = extra_q;
        erase_d      = erase_q;
        erase_addr_d = erase_addr_q;
        mem_we       = 1'b0;
        mem_waddr    = addr_q;
        mem_wdata_n  = '0;

        // Chip erase runs beside the command FSM so the host can poll RDSR meanwhile.
        if (erase_q) begin
            mem_we    = 1'b1;
            mem_waddr = erase_addr_q;
            if (&erase_addr_q) begin
                erase_d = 1'b0;
                wip_d   = 1'b0;
            end else begin
                erase_addr_d = erase_addr_q + 1'b1;
            end
        end else if (wip_q) begin
            if (wip_cnt_q == '0) begin
                wip_d = 1'b0;
            end else begin
                wip_cnt_d = wip_cnt_q - CntW'(1);
            end
        end

        if (commit_q) begin
            mem_we      = 1'b1;
            mem_waddr   = addr_q;
            mem_wdata_n = ~(rd_data_q & tx_q);
            addr_d      = addr_pg;
            committed_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d   = StOpcode;
                    bit_cnt_d = '0;
                end
            end
            StOpcode: begin
                if (sck_rise) begin
                    shift_d   = shift_in[ADDR_BITS-2:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = '0;
                        opcode_d  = shift_in[7:0];
                        extra_d   = 1'b0;
                        state_d   = StSkip;
                        if (wip_q && shift_in[7:0] != OpRdsr) begin
                            opcode_d    = OpNone;
                            cmd_error_d = 1'b1;
                        end else begin
                            case (shift_in[7:0])
                                OpRead: state_d = StAddr;
                                OpPp: begin
                                    if (wel_q) begin
                                        state_d = StAddr;
                                    end else begin
                                        opcode_d    = OpNone;
                                        cmd_error_d = 1'b1;
                                    end
                                end
                                OpRdsr: begin
                                    state_d = StStatus;
                                    load_d  = 1'b1;
                                end
                                default: state_d = StSkip;
                            endcase
                        end
                    end
                end
            end
            StAddr: begin
                if (sck_rise) begin
                    shift_d   = shift_in[ADDR_BITS-2:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = '0;
                        addr_d    = shift_in;
                        if (opcode_q == OpRead) begin
                            state_d = StRead;
                            load_d  = 1'b1;
                        end else begin
                            state_d     = StProg;
                            committed_d = 1'b0;
                        end
                    end
                end
            end
            StRead, StStatus: begin
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = '0;
                        load_d    = 1'b1;
                        if (state_q == StRead) begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end else if (sck_fall) begin
                    if (load_q) begin
                        tx_d   = (state_q == StRead) ? rd_data_q : status;
                        load_d = 1'b0;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                    miso_d = tx_d[7];
                end
            end
            StProg: begin
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    tx_d      = {tx_q[6:0], mosi_s};
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = '0;
                        commit_d  = 1'b1;
                    end
                end
            end
            StSkip: begin
                if (sck_rise) begin
                    extra_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (cs_rise) begin
            state_d   = StIdle;
            miso_d    = 1'b0;
            load_d    = 1'b0;
            bit_cnt_d = '0;
            if (state_q == StSkip && !extra_q) begin
                case (opcode_q)
                    OpWren: wel_d = 1'b1;
                    OpWrdi: wel_d = 1'b0;
                    OpCe: begin
                        if (wel_q) begin
                            erase_d      = 1'b1;
                            erase_addr_d = '0;
                            wip_d        = 1'b1;
                            wel_d        = 1'b0;
                        end else begin
                            cmd_error_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (state_q == StProg && (committed_q || commit_q)) begin
                wel_d     = 1'b0;
                wip_d     = 1'b1;
                wip_cnt_d = CntW'(PROG_CYCLES - 1);
            end
        end
    end

    assign miso_o      = miso_q;
    assign wip_o       = wip_q;
    assign wel_o       = wel_q;
    assign cmd_error_o = cmd_error_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: bit-banged mode-0 SPI master with
// hand-computed expected array, status and timing values.
`timescale 1ns/1ps
module tb_spi_flash_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic cs = 1'b1;
    logic mosi = 1'b0;
    logic miso, wip, wel, cmd_error;

    int checks = 0;
    int failures = 0;
    int wip_run = 0;
    int wip_last = 0;
    int err_cycles = 0;
    logic [7:0] rbuf [8];

    always #5 clk = ~clk;

    spi_flash_responder #(
        .ADDR_BITS  (10),
        .PROG_CYCLES(64)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sck_i      (sck),
        .cs_i       (cs),
        .mosi_i     (mosi),
        .miso_o     (miso),
        .wip_o      (wip),
        .wel_o      (wel),
        .cmd_error_o(cmd_error)
    );

    always @(negedge clk) begin
        if (wip) begin
            wip_run <= wip_run + 1;
        end else begin
            if (wip_run != 0) wip_last <= wip_run;
            wip_run <= 0;
        end
        if (cmd_error) err_cycles <= err_cycles + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            tick(4);
            rx = {rx[6:0], miso};
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(6);
    endtask

    task automatic cs_high();
        tick(6);
        cs = 1'b1;
        mosi = 1'b0;
        tick(8);
    endtask

    task automatic send_cmd(input logic [7:0] op);
        logic [7:0] r;
        cs_low();
        xfer(op, 8, r);
        cs_high();
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [7:0] r;
        xfer(a[23:16], 8, r);
        xfer(a[15:8], 8, r);
        xfer(a[7:0], 8, r);
    endtask

    task automatic spi_read(input logic [23:0] a, input int n);
        logic [7:0] r;
        cs_low();
        xfer(8'h03, 8, r);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, 8, r);
            rbuf[i] = r;
        end
        cs_high();
    endtask

    task automatic spi_pp(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1,
                          input int n);
        logic [7:0] r;
        cs_low();
        xfer(8'h02, 8, r);
        send_addr(a);
        xfer(b0, 8, r);
        if (n > 1) xfer(b1, 8, r);
        cs_high();
    endtask

    task automatic rdsr(output logic [7:0] s);
        logic [7:0] r;
        cs_low();
        xfer(8'h05, 8, r);
        xfer(8'h00, 8, s);
        cs_high();
    endtask

    task automatic wait_wip_low(input int limit);
        int n = 0;
        while (wip && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (wip) begin
            failures++;
            $display("FAIL wip_timeout: wip still %0b after %0d cycles, required 0", wip, limit);
        end
        tick(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(2);
        checks++; if (miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b want 0", miso); end
        checks++; if (wip !== 1'b0) begin failures++; $display("FAIL reset_wip: got %b want 0", wip); end
        checks++; if (wel !== 1'b0) begin failures++; $display("FAIL reset_wel: got %b want 0", wel); end
        checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", cmd_error); end
    endtask

    task automatic test_read_erased();
        spi_read(24'h000010, 4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rbuf[i] !== 8'hFF) begin
                failures++;
                $display("FAIL read_erased[%0d]: got %h want ff", i, rbuf[i]);
            end
        end
    endtask

    task automatic test_program();
        logic [7:0] s;
        send_cmd(8'h06);
        rdsr(s);
        checks++; if (s !== 8'h02) begin failures++; $display("FAIL rdsr_wel: got %h want 02", s); end
        spi_pp(24'h000020, 8'hA5, 8'h3C, 2);
        checks++; if (wip !== 1'b1) begin failures++; $display("FAIL pp_wip_busy: got %b want 1", wip); end
        checks++; if (wel !== 1'b0) begin failures++; $display("FAIL pp_wel_clear: got %b want 0", wel); end
        wait_wip_low(200);
        checks++; if (wip_last !== 64) begin failures++; $display("FAIL pp_wip_len: got %0d want 64", wip_last); end
        rdsr(s);
        checks++; if (s !== 8'h00) begin failures++; $display("FAIL rdsr_idle: got %h want 00", s); end
        spi_read(24'h000020, 2);
        checks++; if (rbuf[0] !== 8'hA5) begin failures++; $display("FAIL pp_byte0: got %h want a5", rbuf[0]); end
        checks++; if (rbuf[1] !== 8'h3C) begin failures++; $display("FAIL pp_byte1: got %h want 3c", rbuf[1]); end
    endtask

    task automatic test_and_wrap();
        send_cmd(8'h06);
        spi_pp(24'h000020, 8'h0F, 8'h00, 1);
        wait_wip_low(200);
        spi_read(24'h000020, 1);
        checks++; if (rbuf[0] !== 8'h05) begin failures++; $display("FAIL pp_and: got %h want 05", rbuf[0]); end
        send_cmd(8'h06);
        spi_pp(24'h0000FF, 8'h12, 8'h34, 2);
        wait_wip_low(200);
        spi_read(24'h0000FF, 1);
        checks++; if (rbuf[0] !== 8'h12) begin failures++; $display("FAIL page_ff: got %h want 12", rbuf[0]); end
        spi_read(24'h000000, 1);
        checks++; if (rbuf[0] !== 8'h34) begin failures++; $display("FAIL page_wrap: got %h want 34", rbuf[0]); end
        spi_read(24'h000100, 1);
        checks++; if (rbuf[0] !== 8'hFF) begin failures++; $display("FAIL page_next: got %h want ff", rbuf[0]); end
        spi_read(24'h0003FF, 2);
        checks++; if (rbuf[0] !== 8'hFF) begin failures++; $display("FAIL rd_top: got %h want ff", rbuf[0]); end
        checks++; if (rbuf[1] !== 8'h34) begin failures++; $display("FAIL rd_wrap: got %h want 34", rbuf[1]); end
    endtask

    task automatic test_protect();
        logic [7:0] r;
        int e0;
        e0 = err_cycles;
        spi_pp(24'h000040, 8'h00, 8'h00, 1);
        tick(2);
        checks++; if (err_cycles - e0 !== 1) begin failures++; $display("FAIL pp_noen_err: got %0d pulse cycles want 1", err_cycles - e0); end
        checks++; if (wip !== 1'b0) begin failures++; $display("FAIL pp_noen_wip: got %b want 0", wip); end
        spi_read(24'h000040, 1);
        checks++; if (rbuf[0] !== 8'hFF) begin failures++; $display("FAIL pp_noen_data: got %h want ff", rbuf[0]); end
        cs_low();
        xfer(8'h06, 5, r);
        cs_high();
        checks++; if (wel !== 1'b0) begin failures++; $display("FAIL wren_trunc: got %b want 0", wel); end
        send_cmd(8'h06);
        checks++; if (wel !== 1'b1) begin failures++; $display("FAIL wren_set: got %b want 1", wel); end
        send_cmd(8'h04);
        checks++; if (wel !== 1'b0) begin failures++; $display("FAIL wrdi_clr: got %b want 0", wel); end
    endtask

    task automatic test_abort_pp();
        logic [7:0] r;
        send_cmd(8'h06);
        cs_low();
        xfer(8'h02, 8, r);
        send_addr(24'h000050);
        xfer(8'h00, 4, r);
        cs_high();
        tick(4);
        checks++; if (wel !== 1'b1) begin failures++; $display("FAIL abort_wel: got %b want 1", wel); end
        checks++; if (wip !== 1'b0) begin failures++; $display("FAIL abort_wip: got %b want 0", wip); end
        spi_read(24'h000050, 1);
        checks++; if (rbuf[0] !== 8'hFF) begin failures++; $display("FAIL abort_data: got %h want ff", rbuf[0]); end
    endtask

    task automatic test_erase();
        logic [7:0] s;
        int e0;
        send_cmd(8'h06);
        send_cmd(8'hC7);
        checks++; if (wip !== 1'b1) begin failures++; $display("FAIL ce_wip: got %b want 1", wip); end
        rdsr(s);
        checks++; if (s !== 8'h01) begin failures++; $display("FAIL ce_rdsr: got %h want 01", s); end
        e0 = err_cycles;
        spi_read(24'h000020, 1);
        checks++; if (err_cycles - e0 !== 1) begin failures++; $display("FAIL ce_read_err: got %0d pulse cycles want 1", err_cycles - e0); end
        checks++; if (rbuf[0] !== 8'h00) begin failures++; $display("FAIL ce_read_miso: got %h want 00", rbuf[0]); end
        wait_wip_low(2000);
        checks++; if (wip_last !== 1024) begin failures++; $display("FAIL ce_wip_len: got %0d want 1024", wip_last); end
        checks++; if (wel !== 1'b0) begin failures++; $display("FAIL ce_wel: got %b want 0", wel); end
        spi_read(24'h000020, 2);
        checks++; if (rbuf[0] !== 8'hFF || rbuf[1] !== 8'hFF) begin failures++; $display("FAIL ce_data20: got %h %h want ff ff", rbuf[0], rbuf[1]); end
        spi_read(24'h000000, 1);
        checks++; if (rbuf[0] !== 8'hFF) begin failures++; $display("FAIL ce_data00: got %h want ff", rbuf[0]); end
    endtask

    task automatic test_rst_erase();
        logic [7:0] s;
        send_cmd(8'h06);
        spi_pp(24'h000300, 8'h5A, 8'h00, 1);
        wait_wip_low(200);
        send_cmd(8'h06);
        spi_pp(24'h000010, 8'h00, 8'h00, 1);
        wait_wip_low(200);
        send_cmd(8'h06);
        send_cmd(8'hC7);
        tick(90);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        checks++; if (wip !== 1'b0) begin failures++; $display("FAIL rst_erase_wip: got %b want 0", wip); end
        checks++; if (wel !== 1'b0) begin failures++; $display("FAIL rst_erase_wel: got %b want 0", wel); end
        rdsr(s);
        checks++; if (s !== 8'h00) begin failures++; $display("FAIL rst_erase_rdsr: got %h want 00", s); end
        spi_read(24'h000010, 1);
        checks++; if (rbuf[0] !== 8'hFF) begin failures++; $display("FAIL rst_erase_done: got %h want ff", rbuf[0]); end
        spi_read(24'h000300, 1);
        checks++; if (rbuf[0] !== 8'h5A) begin failures++; $display("FAIL rst_erase_kept: got %h want 5a", rbuf[0]); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_erased();
        test_program();
        test_and_wrap();
        test_protect();
        test_abort_pp();
        test_erase();
        test_rst_erase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
